// File: rtl/scoreboard_issue_ctrl.sv
// Scoreboard issue controller: per-register latency countdown, hazard hold, wb report.
// Optional operand bypass on the writeback cycle: define SCOREBOARD_BYPASS_EN.
module scoreboard_issue_ctrl #(
  parameter int NREG    = 32,
  parameter int LAT_W   = 3,
  parameter int LAT_MAX = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [4:0]       dec_addr_a,
  input  logic [4:0]       dec_addr_b,
  input  logic             dec_use_a,
  input  logic             dec_use_b,
  input  logic             dec_write,
  input  logic [4:0]       dec_addr_d,
  input  logic [LAT_W-1:0] dec_lat,
  input  logic             flush,
  output logic             issue,
  output logic             stall,
  output logic             hz_raw,
  output logic             hz_waw,
  output logic             hz_wb,
  output logic             wb_valid,
  output logic [4:0]       wb_addr,
  output logic             fwd_a,
  output logic             fwd_b
);

  localparam int AW = 5;
  localparam logic [LAT_W:0] LAT_MAX_X = (LAT_W+1)'(LAT_MAX);

  typedef logic [LAT_W-1:0] cnt_t;

  cnt_t cnt    [NREG];
  cnt_t cnt_nx [NREG];

  logic [NREG-1:0] busy;
  logic [NREG-1:0] slot_hit;

  logic [LAT_W-1:0] lat_eff;
  logic [LAT_W:0]   lat_x;
  logic [LAT_W:0]   slot;

  logic raw_a;
  logic raw_b;
  logic raw_c;
  logic waw_c;
  logic wb_c;
  logic set_en;

  logic          wb_hit;
  logic [AW-1:0] wb_addr_nx;

  // Zero latency means one cycle; oversize values saturate.
  always_comb begin
    lat_x   = {1'b0, dec_lat};
    lat_eff = dec_lat;
    if (dec_lat == '0) begin
      lat_eff = LAT_W'(1);
    end else if (lat_x > LAT_MAX_X) begin
      lat_eff = LAT_W'(LAT_MAX);
    end
  end

  // A new result lands L cycles out; that slot is taken by any cnt of L+1.
  assign slot = {1'b0, lat_eff} + (LAT_W+1)'(1);

  always_comb begin
    busy     = '0;
    slot_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      busy[r]     = (cnt[r] != '0);
      slot_hit[r] = ({1'b0, cnt[r]} == slot);
    end
  end

`ifdef SCOREBOARD_BYPASS_EN
  logic [NREG-1:0] due;

  always_comb begin
    due = '0;
    for (int r = 0; r < NREG; r++) begin
      due[r] = (cnt[r] == LAT_W'(1));
    end
  end

  // A source completing this cycle is picked off the writeback bus.
  assign raw_a = dec_use_a
               & busy[dec_addr_a]
               & ~due[dec_addr_a];
  assign raw_b = dec_use_b
               & busy[dec_addr_b]
               & ~due[dec_addr_b];

  assign fwd_a = dec_use_a
               & due[dec_addr_a]
               & (dec_addr_a != '0);
  assign fwd_b = dec_use_b
               & due[dec_addr_b]
               & (dec_addr_b != '0);
`else
  assign raw_a = dec_use_a & busy[dec_addr_a];
  assign raw_b = dec_use_b & busy[dec_addr_b];

  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign raw_c = raw_a | raw_b;

  assign waw_c = dec_write
               & (dec_addr_d != '0)
               & busy[dec_addr_d];

  assign wb_c  = dec_write & (|slot_hit);

  assign hz_raw = dec_valid & raw_c;
  assign hz_waw = dec_valid & waw_c;
  assign hz_wb  = dec_valid & wb_c;

  assign issue = rst_n
               & dec_valid
               & ~flush
               & ~raw_c
               & ~waw_c
               & ~wb_c;

  assign stall = dec_valid & ~issue;

  assign set_en = issue
                & dec_write
                & (dec_addr_d != '0);

  // WAW hold guarantees the set target is idle, so set never meets decrement.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nx[r] = busy[r] ? (cnt[r] - LAT_W'(1)) : '0;
      if (set_en && (dec_addr_d == AW'(r))) begin
        cnt_nx[r] = lat_eff;
      end
    end
    cnt_nx[0] = '0;
  end

  // Slot hazard keeps at most one counter at 1, so OR-ing indices is exact.
  always_comb begin
    wb_hit     = 1'b0;
    wb_addr_nx = '0;
    for (int r = 0; r < NREG; r++) begin
      if (cnt_nx[r] == LAT_W'(1)) begin
        wb_hit     = 1'b1;
        wb_addr_nx = wb_addr_nx | AW'(r);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      wb_valid <= 1'b0;
      wb_addr  <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_nx[r];
      end
      wb_valid <= wb_hit;
      wb_addr  <= wb_addr_nx;
    end
  end

endmodule

// File: tb/tb_scoreboard_issue_ctrl.sv
// Bench for scoreboard_issue_ctrl: directed scenarios then random traffic.
// Reference model tracks the absolute writeback cycle of each register.
module tb_scoreboard_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dec_valid = 1'b0;
  logic [4:0] dec_addr_a = '0;
  logic [4:0] dec_addr_b = '0;
  logic       dec_use_a = 1'b0;
  logic       dec_use_b = 1'b0;
  logic       dec_write = 1'b0;
  logic [4:0] dec_addr_d = '0;
  logic [2:0] dec_lat = '0;
  logic       flush = 1'b0;
  logic       issue;
  logic       stall;
  logic       hz_raw;
  logic       hz_waw;
  logic       hz_wb;
  logic       wb_valid;
  logic [4:0] wb_addr;
  logic       fwd_a;
  logic       fwd_b;

  int checks = 0;
  int errors = 0;
  int now = 0;
  int wb_cyc [32];
  logic got;
  int k;

  scoreboard_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_valid  (dec_valid),
    .dec_addr_a (dec_addr_a),
    .dec_addr_b (dec_addr_b),
    .dec_use_a  (dec_use_a),
    .dec_use_b  (dec_use_b),
    .dec_write  (dec_write),
    .dec_addr_d (dec_addr_d),
    .dec_lat    (dec_lat),
    .flush      (flush),
    .issue      (issue),
    .stall      (stall),
    .hz_raw     (hz_raw),
    .hz_waw     (hz_waw),
    .hz_wb      (hz_wb),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d observed=%0h expected=%0h",
             tag, now, obs, exp);
    end
  endtask

  function automatic int eff(input int lat);
    if (lat == 0) return 1;
    if (lat > 7) return 7;
    return lat;
  endfunction

  function automatic bit in_flight(input int r);
    return (r != 0) && (wb_cyc[r] >= now);
  endfunction

  function automatic bit src_blocked(input int r);
`ifdef SCOREBOARD_BYPASS_EN
    return in_flight(r) && (wb_cyc[r] != now);
`else
    return in_flight(r);
`endif
  endfunction

  function automatic bit src_fwd(input bit use_x, input int r);
`ifdef SCOREBOARD_BYPASS_EN
    return use_x && (r != 0) && (wb_cyc[r] == now);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit slot_taken(input int c);
    for (int r = 1; r < 32; r++)
      if (wb_cyc[r] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 32; r++) wb_cyc[r] = -1;
  endtask

  task automatic drive(input bit v, input bit ua, input int a,
                       input bit ub, input int b, input bit w,
                       input int d, input int lat, input bit fl);
    dec_valid  = v;
    dec_use_a  = ua;
    dec_addr_a = 5'(a);
    dec_use_b  = ub;
    dec_addr_b = 5'(b);
    dec_write  = w;
    dec_addr_d = 5'(d);
    dec_lat    = 3'(lat);
    flush      = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // One clock: check comb outputs, advance, check registered wb outputs.
  task automatic cycle(output logic iss_obs);
    int  L;
    bit  er, ew, eb, ei;
    bit  ev;
    int  ea;
    #1;
    L  = eff(int'(dec_lat));
    er = 0; ew = 0; eb = 0;
    if (dec_valid) begin
      er = (dec_use_a && src_blocked(dec_addr_a)) ||
           (dec_use_b && src_blocked(dec_addr_b));
      ew = dec_write && (dec_addr_d != 0) && in_flight(dec_addr_d);
      eb = dec_write && slot_taken(now + L);
    end
    ei = dec_valid && !flush && !er && !ew && !eb;
    chk("hz_raw", 32'(hz_raw), 32'(er));
    chk("hz_waw", 32'(hz_waw), 32'(ew));
    chk("hz_wb",  32'(hz_wb),  32'(eb));
    chk("issue",  32'(issue),  32'(ei));
    chk("stall",  32'(stall),  32'(dec_valid && !ei));
    chk("fwd_a",  32'(fwd_a),  32'(src_fwd(dec_use_a, dec_addr_a)));
    chk("fwd_b",  32'(fwd_b),  32'(src_fwd(dec_use_b, dec_addr_b)));
    iss_obs = issue;
    @(posedge clk);
    if (ei && dec_write && dec_addr_d != 0)
      wb_cyc[dec_addr_d] = now + L;
    now++;
    #1;
    ev = 0; ea = 0;
    for (int r = 1; r < 32; r++)
      if (wb_cyc[r] == now) begin ev = 1; ea = r; end
    chk("wb_valid", 32'(wb_valid), 32'(ev));
    if (ev) chk("wb_addr", 32'(wb_addr), 32'(ea));
  endtask

  // Hold the current request until it issues; report cycles waited.
  task automatic hold(input string tag, input int exp_wait);
    logic iss;
    int   n;
    n = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(iss);
      if (iss === 1'b1) begin n = i; break; end
    end
    chk(tag, 32'(n), 32'(exp_wait));
    idle();
  endtask

  task automatic drain(input int n);
    logic iss;
    idle();
    for (int i = 0; i < n; i++) cycle(iss);
  endtask

  initial begin
    clear_model();
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_addr",  32'(wb_addr),  32'd0);
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    #1;
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    now = 0;

    // ADD x5, L=1: issue now, writeback next cycle.
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    hold("add_issue_wait", 0);
    drain(3);

    // LOAD x3, L=3, then a dependent reader of x3.
    drive(1, 0, 0, 0, 0, 1, 3, 3, 0);
    hold("load_issue_wait", 0);
    drive(1, 1, 3, 0, 0, 1, 11, 1, 0);
`ifdef SCOREBOARD_BYPASS_EN
    hold("raw_wait", 2);
`else
    hold("raw_wait", 3);
`endif
    drain(4);

    // Writeback slot collision: A x6 L=4, then B x7 L=3.
    drive(1, 0, 0, 0, 0, 1, 6, 4, 0);
    hold("wbA_wait", 0);
    drive(1, 0, 0, 0, 0, 1, 7, 3, 0);
    hold("wbB_wait", 1);
    drain(6);

    // WAW on x9: second writer waits until x9 is idle.
    drive(1, 0, 0, 0, 0, 1, 9, 5, 0);
    hold("wawA_wait", 0);
    drive(1, 0, 0, 0, 0, 1, 9, 2, 0);
    hold("waw_wait", 5);
    drain(4);

    // x0 is never tracked.
    drive(1, 0, 0, 0, 0, 1, 0, 3, 0);
    hold("x0w_wait", 0);
    drive(1, 1, 0, 1, 0, 0, 0, 1, 0);
    hold("x0r_wait", 0);
    drain(5);

    // Flush blocks issue; the held request goes next cycle.
    drive(1, 0, 0, 0, 0, 1, 12, 2, 0);
    hold("pre_flush_wait", 0);
    drive(1, 0, 0, 0, 0, 1, 10, 2, 1);
    cycle(got);
    chk("flush_issue", 32'(got), 32'd0);
    flush = 1'b0;
    hold("post_flush_wait", 0);
    drain(4);

    // Async reset while x4 has two cycles left.
    drive(1, 0, 0, 0, 0, 1, 4, 3, 0);
    hold("x4_wait", 0);
    drain(1);
    drive(1, 1, 4, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_issue", 32'(issue), 32'd0);
    chk("mid_rst_wb",    32'(wb_valid), 32'd0);
    clear_model();
    idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    now += 2;
    drain(5);

    // Random traffic over a small register window.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7) == 0);
      cycle(got);
    end
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
